spi_slave_port: RTL and testbench

SPI_SLAVE_PORT -- requirements
Module: spi_slave_port

---
 rtl/spi_slave_pkg.sv | 12 +
 rtl/spi_sync_edge.sv | 42 ++++
 rtl/spi_slave_port.sv | 168 ++++++++++++++++
 tb/tb_spi_slave_port.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and sizes for the SPI slave port.
package spi_slave_pkg;

  localparam int FRAME_W = 8;
  localparam int CNT_W   = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input with rise/fall pulses.
// Edges are taken between the synchronizer output and a one-cycle-delayed
// copy of it. Edge pulses are held off after reset until the chain and the
// delayed copy both hold genuinely sampled input, so a line that sits away
// from its reset level never produces a phantom edge.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [SYNC_STAGES:0]   live_q;
  logic                   lvl;

  assign lvl = sync_q[SYNC_STAGES-1];

  // Synchronizer chain, delayed copy for edge detect, and post-reset warm-up.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      live_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q    <= lvl;
      live_q[0] <= 1'b1;
      for (int i = 1; i <= SYNC_STAGES; i++) live_q[i] <= live_q[i-1];
    end
  end

  assign rise_o = live_q[SYNC_STAGES] &  lvl & ~prev_q;
  assign fall_o = live_q[SYNC_STAGES] & ~lvl &  prev_q;

endmodule

// File: rtl/spi_slave_port.sv
// SPI mode-0 slave, MSB first, 8-bit frames, oversampled by clk.
// One-deep TX buffer feeds the TX shifter; received bytes are presented on
// rx_data with a one-cycle rx_valid pulse.
module spi_slave_port
  import spi_slave_pkg::*;
#(
  parameter int                 SYNC_STAGES = 2,
  parameter logic [FRAME_W-1:0] IDLE_BYTE   = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sclk,
  input  logic               cs,
  input  logic               mosi,
  output logic               miso,
  output logic               miso_oe,
  input  logic [FRAME_W-1:0] tx_data,
  input  logic               tx_load,
  output logic               tx_ready,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  output logic               tx_underrun,
  output logic               frame_err,
  output logic               busy
);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  state_e             state_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [FRAME_W-2:0] rx_shift_q;
  // miso_q is the shifter MSB; tx_shift_q holds the bits still to follow.
  logic [FRAME_W-2:0] tx_shift_q;
  logic [FRAME_W-1:0] buf_q;
  logic               tx_ready_q;
  logic [FRAME_W-1:0] rx_data_q;
  logic               rx_valid_q, underrun_q, frame_err_q, busy_q;
  logic               miso_q, miso_oe_q;

  logic [FRAME_W-1:0] reload_byte_d;
  logic               reload_from_buf_d, reload_underrun_d, do_reload_d;
  logic [FRAME_W-1:0] rx_next_d;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (cs),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // Level-only synchronizer for mosi; it is sampled on sclk rise events.
  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q[0] <= mosi;
      for (int i = 1; i < SYNC_STAGES; i++) mosi_sync_q[i] <= mosi_sync_q[i-1];
    end
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Reload source selection: full buffer first, then a same-cycle tx_load
  // bypass, otherwise the idle byte (an underrun).
  always_comb begin
    reload_byte_d     = IDLE_BYTE;
    reload_from_buf_d = 1'b0;
    reload_underrun_d = 1'b0;
    if (!tx_ready_q) begin
      reload_byte_d     = buf_q;
      reload_from_buf_d = 1'b1;
    end else if (tx_load) begin
      reload_byte_d     = tx_data;
    end else begin
      reload_underrun_d = 1'b1;
    end
    do_reload_d = ((state_q == ST_IDLE) && cs_fall) ||
                  ((state_q == ST_ACTIVE) && !cs_rise && sclk_fall && (bit_cnt_q == '0));
    rx_next_d   = {rx_shift_q, mosi_s};
  end

  // Frame FSM with TX buffer, shifters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      tx_ready_q  <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;

      if (do_reload_d) begin
        tx_shift_q <= reload_byte_d[FRAME_W-2:0];
        miso_q     <= reload_byte_d[FRAME_W-1];
        underrun_q <= reload_underrun_d;
        if (reload_from_buf_d) tx_ready_q <= 1'b1;
      end else if (tx_load && tx_ready_q) begin
        buf_q      <= tx_data;
        tx_ready_q <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_q   <= ST_ACTIVE;
            bit_cnt_q <= '0;
            miso_oe_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            // Any partial RX byte is simply abandoned; rx_data is untouched.
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= (bit_cnt_q != '0);
          end else begin
            if (sclk_rise) begin
              rx_shift_q <= rx_next_d[FRAME_W-2:0];
              bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
              if (bit_cnt_q == '1) begin
                rx_data_q  <= rx_next_d;
                rx_valid_q <= 1'b1;
              end
            end
            if (sclk_fall && (bit_cnt_q != '0)) begin
              miso_q     <= tx_shift_q[FRAME_W-2];
              tx_shift_q <= {tx_shift_q[FRAME_W-3:0], 1'b0};
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: a behavioural SPI master drives frames, the
// expected MISO stream is the sequence of bytes handed to the slave (idle
// byte when none was available), and the expected RX stream is what was sent.
`timescale 1ns/1ps
module tb_spi_slave_port;

  localparam int         SYNC = 2;
  localparam logic [7:0] IDLE = 8'h00;

  logic       clk, rst, sclk, cs, mosi, miso, miso_oe;
  logic [7:0] tx_data, rx_data;
  logic       tx_load, tx_ready, rx_valid, tx_underrun, frame_err, busy;

  spi_slave_port #(.SYNC_STAGES(SYNC), .IDLE_BYTE(IDLE)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .frame_err(frame_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int rxv_cnt = 0, und_cnt = 0, fe_cnt = 0;
  logic [7:0] rx_log[$];
  logic [7:0] mq[$], fq[$], sq[$], txb[$];
  int jit_max = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rxv_cnt++;
      rx_log.push_back(rx_data);
    end
    if (tx_underrun === 1'b1) und_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic half_wait();
    int p;
    repeat (4) @(negedge clk);
    if (jit_max > 0) begin
      p = $urandom_range(jit_max, 0);
      if (p == 5) p = 6;
      #(p);
    end
  endtask

  task automatic load_byte(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic end_frame();
    half_wait();
    cs = 1'b1;
    half_wait();
    sclk = 1'b0;
    half_wait();
  endtask

  // Master: sends mq, captures MISO bytes into sq, feeds fq mid-byte.
  // The last rise of a frame is followed by cs rising while sclk is high.
  task automatic xfer(input int stop_bits, input bit hold_cs, input bit inject);
    int nb;
    logic [7:0] mb, sb;
    nb = 0;
    sq.delete();
    cs = 1'b0;
    for (int k = 0; k < mq.size(); k++) begin
      mb = mq[k];
      sb = '0;
      for (int i = 7; i >= 0; i--) begin
        mosi = mb[i];
        half_wait();
        sb[i] = miso;
        sclk = 1'b1;
        nb++;
        if (stop_bits != 0 && nb == stop_bits) begin
          if (!hold_cs) end_frame();
          return;
        end
        half_wait();
        if (i == 4 && fq.size() > 0) load_byte(fq.pop_front());
        if (k < mq.size() - 1 || i > 0) begin
          sclk = 1'b0;
          if (inject && k == 0 && i == 0) begin
            repeat (SYNC) @(posedge clk);
            #1;
            tx_data = 8'h7E;
            tx_load = 1'b1;
            @(posedge clk);
            #1;
            tx_load = 1'b0;
            check_eq("bypass_tx_ready", tx_ready, 1);
          end
        end
      end
      sq.push_back(sb);
    end
    end_frame();
  endtask

  int b_rxv, b_und, b_fe, base, n, sent;

  initial begin
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tx_load = 1'b0; tx_data = 8'h00;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("rst_miso", miso, 0);
    check_eq("rst_miso_oe", miso_oe, 0);
    check_eq("rst_tx_ready", tx_ready, 1);
    check_eq("rst_rx_data", rx_data, 0);
    check_eq("rst_pulses", {rx_valid, tx_underrun, frame_err}, 0);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Single byte: respond 0xA5, receive 0x3C.
    b_rxv = rxv_cnt; b_und = und_cnt;
    load_byte(8'hA5);
    check_eq("t1_tx_ready_loaded", tx_ready, 0);
    mq = '{8'h3C}; fq.delete();
    xfer(0, 0, 0);
    check_eq("t1_miso", sq[0], 8'hA5);
    check_eq("t1_rx_data", rx_data, 8'h3C);
    check_eq("t1_rx_valid_cnt", rxv_cnt - b_rxv, 1);
    check_eq("t1_tx_ready", tx_ready, 1);
    check_eq("t1_underrun", und_cnt - b_und, 0);
    check_eq("t1_idle_oe", miso_oe, 0);
    check_eq("t1_idle_busy", busy, 0);

    // Burst of three with one byte preloaded.
    b_rxv = rxv_cnt; b_und = und_cnt; base = rx_log.size();
    load_byte(8'h11);
    mq = '{8'h01, 8'h02, 8'h03}; fq.delete();
    xfer(0, 0, 0);
    check_eq("t2_miso0", sq[0], 8'h11);
    check_eq("t2_miso1", sq[1], IDLE);
    check_eq("t2_miso2", sq[2], IDLE);
    check_eq("t2_underrun", und_cnt - b_und, 2);
    check_eq("t2_rx_cnt", rxv_cnt - b_rxv, 3);
    if (rx_log.size() == base + 3)
      check_eq("t2_rx_bytes", {rx_log[base], rx_log[base+1], rx_log[base+2]}, 24'h010203);

    // Abort after five bits, buffer loaded during the aborted byte.
    b_rxv = rxv_cnt; b_und = und_cnt; b_fe = fe_cnt;
    mq = '{8'hC3}; fq = '{8'h99};
    xfer(5, 0, 0);
    check_eq("t3_frame_err", fe_cnt - b_fe, 1);
    check_eq("t3_no_rx_valid", rxv_cnt - b_rxv, 0);
    check_eq("t3_rx_held", rx_data, 8'h03);
    check_eq("t3_underrun", und_cnt - b_und, 1);
    check_eq("t3_buffer_kept", tx_ready, 0);
    b_rxv = rxv_cnt; b_fe = fe_cnt;
    mq = '{8'hFF}; fq.delete();
    xfer(0, 0, 0);
    check_eq("t3_next_miso", sq[0], 8'h99);
    check_eq("t3_next_rx", rx_data, 8'hFF);
    check_eq("t3_next_rx_cnt", rxv_cnt - b_rxv, 1);
    check_eq("t3_next_fe", fe_cnt - b_fe, 0);

    // tx_load landing exactly on the reload with an empty buffer.
    b_und = und_cnt; base = rx_log.size();
    load_byte(8'h5A);
    mq = '{8'h12, 8'h34}; fq.delete();
    xfer(0, 0, 1);
    check_eq("t4_miso0", sq[0], 8'h5A);
    check_eq("t4_miso1", sq[1], 8'h7E);
    check_eq("t4_underrun", und_cnt - b_und, 0);
    check_eq("t4_tx_ready", tx_ready, 1);
    if (rx_log.size() == base + 2)
      check_eq("t4_rx_bytes", {rx_log[base], rx_log[base+1]}, 16'h1234);
    else
      check_eq("t4_rx_count", rx_log.size() - base, 2);

    // Reset in the middle of a frame, then sclk activity with cs still low.
    load_byte(8'h66);
    mq = '{8'hAB}; fq.delete();
    xfer(4, 1, 0);
    check_eq("t5_busy_before", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_miso", miso, 0);
    check_eq("t5_miso_oe", miso_oe, 0);
    check_eq("t5_tx_ready", tx_ready, 1);
    check_eq("t5_rx_data", rx_data, 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_pulses", {rx_valid, tx_underrun, frame_err}, 0);
    @(negedge clk);
    rst = 1'b0;
    b_rxv = rxv_cnt;
    for (int i = 0; i < 10; i++) begin
      sclk = 1'b0; half_wait();
      sclk = 1'b1; half_wait();
    end
    check_eq("t5_no_rx_valid", rxv_cnt - b_rxv, 0);
    check_eq("t5_still_idle", {busy, miso_oe}, 0);
    cs = 1'b1; half_wait();
    sclk = 1'b0; half_wait();
    load_byte(8'h21);
    mq = '{8'h5C}; fq.delete();
    xfer(0, 0, 0);
    check_eq("t5_reacq_miso", sq[0], 8'h21);
    check_eq("t5_reacq_rx", rx_data, 8'h5C);

    // Random loopback at clk/8 with random edge phase.
    jit_max = 9;
    b_und = und_cnt;
    sent = 0;
    while (sent < 1000) begin
      n = $urandom_range(12, 1);
      if (sent + n > 1000) n = 1000 - sent;
      mq.delete(); txb.delete(); fq.delete();
      for (int j = 0; j < n; j++) begin
        mq.push_back(8'($urandom));
        txb.push_back(8'($urandom));
      end
      for (int j = 1; j < n; j++) fq.push_back(txb[j]);
      base = rx_log.size();
      load_byte(txb[0]);
      xfer(0, 0, 0);
      check_eq("rand_miso_count", sq.size(), n);
      check_eq("rand_rx_count", rx_log.size() - base, n);
      for (int j = 0; j < n; j++) begin
        if (j < sq.size()) check_eq("rand_miso", sq[j], txb[j]);
        if (base + j < rx_log.size()) check_eq("rand_rx", rx_log[base+j], mq[j]);
      end
      sent += n;
    end
    check_eq("rand_underrun", und_cnt - b_und, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
